// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   C_BCD_BLANK   : digit code shown for a blanked leading zero
//   C_BCD_ADD3_TH : threshold at which a digit is corrected by +3 before shifting
//   state_e       : converter FSM states
//   clog2         : elaboration-time ceiling log2, sizes the bit counter
package bin2bcd_pkg;

    localparam logic [3:0] C_BCD_BLANK   = 4'hF;
    localparam logic [3:0] C_BCD_ADD3_TH = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        int unsigned pow;
        res = 0;
        pow = 1;
        while (pow < val) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of the binary-to-BCD converter.
//   DAT_i  : binary operand            REQ_i  : start request
//   BUSY_o : conversion in progress    DONE_o : one-cycle result strobe
//   QQ_o   : BCD digits, digit 0 low   NEG_o  : operand was negative
//   OVF_o  : value exceeded the digit count
// master = requester side, slave = converter side.
interface bin2bcd_seq_if #(
    parameter int unsigned C_BIN_W  = 27,
    parameter int unsigned C_DIGITS = 9
) ();

    logic [C_BIN_W-1:0]    DAT_i;
    logic                  REQ_i;
    logic                  BUSY_o;
    logic                  DONE_o;
    logic [4*C_DIGITS-1:0] QQ_o;
    logic                  NEG_o;
    logic                  OVF_o;

    modport master (
        output DAT_i,
        output REQ_i,
        input  BUSY_o,
        input  DONE_o,
        input  QQ_o,
        input  NEG_o,
        input  OVF_o
    );

    modport slave (
        input  DAT_i,
        input  REQ_i,
        output BUSY_o,
        output DONE_o,
        output QQ_o,
        output NEG_o,
        output OVF_o
    );

endinterface

// File: rtl/bin2bcd_digit.sv
// One BCD digit of the shift-add-3 (double dabble) chain.
//   CK_i, XARST_i : clock, asynchronous active-low reset
//   EN_CK_i       : clock enable, digit holds when low
//   clr_i         : synchronous clear (start of a conversion)
//   shift_i       : correct-then-shift this cycle
//   cyi_i         : bit shifted in from the digit below (or the operand MSB)
//   cyo_o         : bit shifted out towards the digit above
//   dig_o         : current digit value
module bin2bcd_digit
    import bin2bcd_pkg::*;
(
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       EN_CK_i,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic       cyi_i,
    output logic       cyo_o,
    output logic [3:0] dig_o
);

    logic [3:0] dig_q;
    logic [3:0] dig_d;
    logic [3:0] adj;

    always_comb begin
        // Digits stay in 0..9, so the corrected value is at most 12 and its bit 3
        // is exactly the decimal carry produced by the following doubling.
        adj   = (dig_q >= C_BCD_ADD3_TH) ? (dig_q + 4'd3) : dig_q;
        cyo_o = adj[3];
        dig_d = dig_q;
        if (clr_i) begin
            dig_d = 4'h0;
        end else if (shift_i) begin
            dig_d = {adj[2:0], cyi_i};
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            dig_q <= 4'h0;
        end else if (EN_CK_i) begin
            dig_q <= dig_d;
        end
    end

    assign dig_o = dig_q;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per enabled clock.
//   CK_i    : clock, rising edge
//   XARST_i : asynchronous active-low reset
//   EN_CK_i : clock enable, all state freezes when low (DONE_o included)
//   bus_io  : request/result bundle (slave side), see bin2bcd_seq_if
// A request in idle loads the operand magnitude; C_BIN_W shift cycles follow,
// then one latch cycle registers QQ_o/NEG_o/OVF_o and pulses DONE_o.
// Build option BIN2BCD_SEQ_LZB_EN: blank leading zero digits (digit 0 never
// blanked) with the blank code when the result is latched.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned C_BIN_W  = 27,
    parameter int unsigned C_DIGITS = 9,
    parameter int unsigned C_SIGNED = 0
) (
    input  logic CK_i,
    input  logic XARST_i,
    input  logic EN_CK_i,
    bin2bcd_seq_if.slave bus_io
);

    localparam int unsigned CntW = clog2(C_BIN_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(C_BIN_W - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [C_BIN_W-1:0]    sr_q, sr_d;
    logic                  neg_cap_q, neg_cap_d;
    logic                  ovf_cap_q, ovf_cap_d;
    logic [4*C_DIGITS-1:0] qq_q, qq_d;
    logic                  neg_q, neg_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic                  load;
    logic                  shift;
    logic                  is_neg;
    logic [C_BIN_W-1:0]    mag;
    logic [C_DIGITS:0]     cy;
    logic [4*C_DIGITS-1:0] dig_all;
    logic [4*C_DIGITS-1:0] qq_fmt;

    // The most negative operand negates to 2^(C_BIN_W-1), which is still
    // the correct unsigned magnitude.
    assign is_neg = (C_SIGNED != 0) && bus_io.DAT_i[C_BIN_W-1];
    assign mag    = is_neg ? (~bus_io.DAT_i + C_BIN_W'(1)) : bus_io.DAT_i;

    assign cy[0] = sr_q[C_BIN_W-1];

    for (genvar gi = 0; gi < int'(C_DIGITS); gi++) begin : g_digit
        bin2bcd_digit u_digit (
            .CK_i    (CK_i),
            .XARST_i (XARST_i),
            .EN_CK_i (EN_CK_i),
            .clr_i   (load),
            .shift_i (shift),
            .cyi_i   (cy[gi]),
            .cyo_o   (cy[gi+1]),
            .dig_o   (dig_all[4*gi +: 4])
        );
    end

`ifdef BIN2BCD_SEQ_LZB_EN
    logic nz_seen;

    always_comb begin
        qq_fmt  = dig_all;
        nz_seen = 1'b0;
        for (int i = int'(C_DIGITS) - 1; i >= 1; i--) begin
            if (dig_all[4*i +: 4] != 4'h0) begin
                nz_seen = 1'b1;
            end
            if (!nz_seen) begin
                qq_fmt[4*i +: 4] = C_BCD_BLANK;
            end
        end
    end
`else
    assign qq_fmt = dig_all;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        neg_cap_d = neg_cap_q;
        ovf_cap_d = ovf_cap_q;
        qq_d      = qq_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.REQ_i) begin
                    load      = 1'b1;
                    sr_d      = mag;
                    neg_cap_d = is_neg;
                    ovf_cap_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift     = 1'b1;
                sr_d      = sr_q << 1;
                cnt_d     = cnt_q + CntW'(1);
                // A carry out of the top digit means the value needs more digits.
                ovf_cap_d = ovf_cap_q | cy[C_DIGITS];
                if (cnt_q == CntLast) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                qq_d    = qq_fmt;
                neg_d   = neg_cap_q;
                ovf_d   = ovf_cap_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sr_q      <= '0;
            neg_cap_q <= 1'b0;
            ovf_cap_q <= 1'b0;
            qq_q      <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (EN_CK_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            neg_cap_q <= neg_cap_d;
            ovf_cap_q <= ovf_cap_d;
            qq_q      <= qq_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.BUSY_o = (state_q != StIdle);
    assign bus_io.DONE_o = done_q;
    assign bus_io.QQ_o   = qq_q;
    assign bus_io.NEG_o  = neg_q;
    assign bus_io.OVF_o  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three instances (27b/9 digits, 27b/8 digits, 16b signed/5 digits)
// run the same operands side by side against a decimal reference model.
module tb_bin2bcd_seq;

    logic ck = 1'b0;
    logic xarst = 1'b0;
    logic en = 1'b1;

    always #5 ck = ~ck;

    bin2bcd_seq_if #(.C_BIN_W(27), .C_DIGITS(9)) if_a ();
    bin2bcd_seq_if #(.C_BIN_W(27), .C_DIGITS(8)) if_b ();
    bin2bcd_seq_if #(.C_BIN_W(16), .C_DIGITS(5)) if_c ();

    bin2bcd_seq #(.C_BIN_W(27), .C_DIGITS(9), .C_SIGNED(0)) u_a (
        .CK_i(ck), .XARST_i(xarst), .EN_CK_i(en), .bus_io(if_a)
    );
    bin2bcd_seq #(.C_BIN_W(27), .C_DIGITS(8), .C_SIGNED(0)) u_b (
        .CK_i(ck), .XARST_i(xarst), .EN_CK_i(en), .bus_io(if_b)
    );
    bin2bcd_seq #(.C_BIN_W(16), .C_DIGITS(5), .C_SIGNED(1)) u_c (
        .CK_i(ck), .XARST_i(xarst), .EN_CK_i(en), .bus_io(if_c)
    );

    logic [63:0] qq_s [3];
    logic        done_s [3];
    logic        busy_s [3];
    logic        neg_s [3];
    logic        ovf_s [3];

    assign qq_s[0] = 64'(if_a.QQ_o);
    assign qq_s[1] = 64'(if_b.QQ_o);
    assign qq_s[2] = 64'(if_c.QQ_o);
    assign done_s[0] = if_a.DONE_o;
    assign done_s[1] = if_b.DONE_o;
    assign done_s[2] = if_c.DONE_o;
    assign busy_s[0] = if_a.BUSY_o;
    assign busy_s[1] = if_b.BUSY_o;
    assign busy_s[2] = if_c.BUSY_o;
    assign neg_s[0] = if_a.NEG_o;
    assign neg_s[1] = if_b.NEG_o;
    assign neg_s[2] = if_c.NEG_o;
    assign ovf_s[0] = if_a.OVF_o;
    assign ovf_s[1] = if_b.OVF_o;
    assign ovf_s[2] = if_c.OVF_o;

    int w_k [3] = '{27, 27, 16};
    int d_k [3] = '{9, 8, 5};

`ifdef BIN2BCD_SEQ_LZB_EN
    localparam logic [63:0] Exp405 = 64'hF_FFFF_F405;
`else
    localparam logic [63:0] Exp405 = 64'h0_0000_0405;
`endif

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, overflow if anything remains.
    task automatic model(input logic [63:0] v, input int k, output logic [63:0] q,
                         output logic neg, output logic ovf);
        longint unsigned mag;
        logic [15:0] v16;
        bit seen;
        neg = 1'b0;
        if (k == 2) begin
            v16 = v[15:0];
            neg = v16[15];
            mag = neg ? (64'd65536 - {48'd0, v16}) : {48'd0, v16};
        end else begin
            mag = {37'd0, v[26:0]};
        end
        q = '0;
        for (int i = 0; i < d_k[k]; i++) begin
            q[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        ovf = (mag != 0);
`ifdef BIN2BCD_SEQ_LZB_EN
        seen = 1'b0;
        for (int i = d_k[k] - 1; i >= 1; i--) begin
            if (q[4*i +: 4] != 4'h0) seen = 1'b1;
            if (!seen) q[4*i +: 4] = 4'hF;
        end
`else
        seen = 1'b0;
`endif
    endtask

    task automatic drive(input logic [63:0] v);
        if_a.DAT_i = v[26:0];
        if_b.DAT_i = v[26:0];
        if_c.DAT_i = v[15:0];
    endtask

    task automatic set_req(input logic r);
        if_a.REQ_i = r;
        if_b.REQ_i = r;
        if_c.REQ_i = r;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_qq%0d", tag, k), qq_s[k], 64'd0);
            check($sformatf("%s_busy%0d", tag, k), {63'd0, busy_s[k]}, 64'd0);
            check($sformatf("%s_done%0d", tag, k), {63'd0, done_s[k]}, 64'd0);
            check($sformatf("%s_neg%0d", tag, k), {63'd0, neg_s[k]}, 64'd0);
            check($sformatf("%s_ovf%0d", tag, k), {63'd0, ovf_s[k]}, 64'd0);
        end
    endtask

    // One conversion on all three instances. toggle: enable low every other cycle;
    // repulse: new REQ/DAT while busy; rst_at: cycle to pulse reset (0 = none).
    task automatic run(input logic [63:0] v, input bit toggle, input bit repulse,
                       input int rst_at);
        int lat [3];
        int dw [3];
        int chg [3];
        logic [63:0] qq0 [3];
        logic [63:0] eq;
        logic eneg, eovf;
        int elat, edw, limit;
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1;
            dw[k] = 0;
            chg[k] = 0;
            qq0[k] = qq_s[k];
        end
        limit = toggle ? 80 : 40;
        drive(v);
        set_req(1'b1);
        en = 1'b1;
        @(posedge ck);
        #1;
        set_req(1'b0);
        for (int c = 1; c <= limit; c++) begin
            en = toggle ? logic'(c % 2 == 0) : 1'b1;
            if (repulse && c == 6) begin
                drive(~v);
                set_req(1'b1);
            end
            if (repulse && c == 7) set_req(1'b0);
            @(posedge ck);
            #1;
            if (rst_at != 0 && c == rst_at) begin
                xarst = 1'b0;
                #1;
                check_reset_outputs("midrst");
            end
            if (rst_at != 0 && c == rst_at + 3) xarst = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (done_s[k]) begin
                    dw[k]++;
                    if (lat[k] < 0) lat[k] = c;
                end
                if (lat[k] < 0 && (rst_at == 0 || c < rst_at) && qq_s[k] !== qq0[k]) chg[k]++;
            end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model(v, k, eq, eneg, eovf);
            if (rst_at != 0) begin
                eq = '0;
                eneg = 1'b0;
                eovf = 1'b0;
                elat = -1;
                edw = 0;
            end else begin
                elat = (w_k[k] + 1) * (toggle ? 2 : 1);
                edw = toggle ? 2 : 1;
            end
            check($sformatf("lat%0d", k), 64'(lat[k]), 64'(elat));
            check($sformatf("done_width%0d", k), 64'(dw[k]), 64'(edw));
            check($sformatf("qq%0d", k), qq_s[k], eq);
            check($sformatf("neg%0d", k), {63'd0, neg_s[k]}, {63'd0, eneg});
            check($sformatf("ovf%0d", k), {63'd0, ovf_s[k]}, {63'd0, eovf});
            check($sformatf("hold%0d", k), 64'(chg[k]), 64'd0);
            check($sformatf("idle%0d", k), {63'd0, busy_s[k]}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] eq;
        logic eneg, eovf;
        int t0 [3];
        int t1 [3];

        set_req(1'b0);
        drive(64'd0);
        #12;
        check_reset_outputs("reset");
        xarst = 1'b1;
        @(posedge ck);
        #1;

        run(64'd134217727, 1'b0, 1'b0, 0);
        check("lit_max27", qq_s[0], 64'h1_3421_7727);
        check("lit_s16_ffff", qq_s[2], 64'h0_0001);
        run(64'd123456789, 1'b0, 1'b0, 0);
        check("lit_d8_qq", qq_s[1], 64'h2345_6789);
        check("lit_d8_ovf", {63'd0, ovf_s[1]}, 64'd1);
        run(64'd99999999, 1'b0, 1'b0, 0);
        check("lit_d8_fit", qq_s[1], 64'h9999_9999);
        run(64'h8000, 1'b0, 1'b0, 0);
        check("lit_s16_neg", {63'd0, neg_s[2]}, 64'd1);
        check("lit_s16_8000", qq_s[2], 64'h3_2768);
        run(64'd405, 1'b0, 1'b0, 0);
        check("lit_405", qq_s[0], Exp405);
        run(64'd0, 1'b0, 1'b0, 0);

        repeat (6) begin
            v = {$urandom, $urandom};
            run(v, 1'b0, 1'b0, 0);
        end

        run({$urandom, $urandom}, 1'b0, 1'b1, 0);
        run({$urandom, $urandom}, 1'b1, 1'b0, 0);
        run({$urandom, $urandom}, 1'b0, 1'b0, 10);

        // REQ_i held high: back-to-back conversions.
        v = {$urandom, $urandom};
        drive(v);
        set_req(1'b1);
        for (int k = 0; k < 3; k++) begin
            t0[k] = -1;
            t1[k] = -1;
        end
        for (int c = 0; c < 100; c++) begin
            @(posedge ck);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done_s[k]) begin
                    if (t0[k] < 0) begin
                        t0[k] = c;
                        model(v, k, eq, eneg, eovf);
                        check($sformatf("b2b_qq%0d", k), qq_s[k], eq);
                    end else if (t1[k] < 0) begin
                        t1[k] = c;
                    end
                end
            end
        end
        set_req(1'b0);
        repeat (40) @(posedge ck);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_period%0d", k), 64'(t1[k] - t0[k]), 64'(w_k[k] + 2));
            check($sformatf("b2b_idle%0d", k), {63'd0, busy_s[k]}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter (shift-add-3), successor to the fixed 27-bit/8-digit shift converter.
- Generalised input width and digit count; optional two's-complement input.
- Adds a REQ/BUSY/DONE handshake, an overflow flag and a sign flag.
- Sits between counters/measurement logic and display or UART formatting blocks.

Parameters:
- C_BIN_W, 27, binary input width (2..64).
- C_DIGITS, 9, BCD output digits (1..20).
- C_SIGNED, 0, 1 = DAT_i is two's complement; the magnitude is converted.

Ports:
- CK_i  in  1  clock, rising edge.
- XARST_i  in  1  reset, asynchronous, active-low.
- EN_CK_i  in  1  clock enable. When low, all state holds.
- DAT_i  in  C_BIN_W  binary operand.
- REQ_i  in  1  start request, 1-cycle pulse or level.
- BUSY_o  out  1  conversion in progress. REQ_i is ignored while high.
- DONE_o  out  1  1-cycle pulse. Result valid in QQ_o/NEG_o/OVF_o.
- QQ_o  out  4*C_DIGITS  BCD result, digit 0 in [3:0].
- NEG_o  out  1  operand was negative (C_SIGNED only, else 0).
- OVF_o  out  1  value does not fit in C_DIGITS; QQ_o holds the low digits only.

Behaviour:
- Reset: BUSY_o=0, DONE_o=0, QQ_o=0, NEG_o=0, OVF_o=0. Shift register, digit regs and counter cleared. States apply immediately on XARST_i low.
- All transitions below are qualified by EN_CK_i=1. With EN_CK_i=0 everything freezes, including a DONE_o already high.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - REQ_i=1 loads the magnitude into the shift reg, clears digit regs, overflow and counter, and captures the sign.
  - Then goes to SHIFT and sets BUSY_o=1.
- Magnitude: if C_SIGNED and DAT_i[MSB]=1, use (~DAT_i+1) as unsigned C_BIN_W. The most negative value gives 2^(C_BIN_W-1), which is correct. Otherwise DAT_i unchanged.
- SHIFT, one bit per enabled clock, MSB first, exactly C_BIN_W cycles:
  - Each digit: if ≥5, add 3, then shift left with carry-in from the lower digit.
  - Digit 0 takes the shift-reg MSB.
  - Carry out of the top digit sets a sticky overflow.
- Counter width: clog2(C_BIN_W+1). After the C_BIN_W-th shift, go to LATCH.
- LATCH, one cycle: QQ_o, NEG_o, OVF_o register the result. DONE_o=1 for that following cycle, BUSY_o=0, return to IDLE.
- Latency: REQ_i accepted at edge 0, DONE_o asserted after edge C_BIN_W+1 (28 for the default). The next REQ_i can be accepted on the same edge at which DONE_o falls.
- QQ_o/NEG_o/OVF_o hold until the next LATCH. They do not change during a conversion.
- REQ_i while BUSY_o=1: ignored, with no restart and no error.
- REQ_i continuously high: back-to-back conversions, one every C_BIN_W+2 cycles.
- Reset mid-conversion: aborts, outputs return to their reset values, and no DONE_o is issued.
- Operand 0 gives QQ_o=0, NEG_o=0, OVF_o=0.

Optional Feature:
- Macro BIN2BCD_SEQ_LZB_EN. When defined, leading-zero blanking is applied at LATCH.
  - Every digit above the most significant nonzero digit is replaced by 4'hF (blank code).
  - Digit 0 is never blanked, so a value of 0 shows as ...FFF0.
- When undefined, leading zeros are output as 4'h0.
- Timing, handshake, NEG_o and OVF_o are identical in both builds.

Decomposition:
- Package bin2bcd_pkg:
  - Constants C_BCD_BLANK=4'hF and C_BCD_ADD3_TH=4'd5.
  - State enum typedef (IDLE/SHIFT/LATCH).
  - clog2 helper function for the counter width.
- Sub-module bin2bcd_digit: one 4-bit dabble cell (add-3-if-≥5, shift with cyi_i/cyo_o, sync clear).
  - Instantiated C_DIGITS times in a generate loop.

Test Plan:
- Defaults, DAT_i=134217727 (max 27-bit) → after 28 cycles DONE_o=1, QQ_o=36'h134217727, OVF_o=0, NEG_o=0.
- C_DIGITS=8, DAT_i=123456789 → QQ_o=32'h23456789, OVF_o=1. Then DAT_i=99999999 → QQ_o=32'h99999999, OVF_o=0.
- C_SIGNED=1, C_BIN_W=16: DAT_i=16'h8000 → NEG_o=1, QQ_o=...32768. DAT_i=16'hFFFF → NEG_o=1, QQ_o=...00001.
- REQ_i re-pulsed at cycle 5 of a busy conversion with a new value → ignored, first result returned. REQ_i held high → DONE_o every 29 cycles.
- EN_CK_i toggled 50% during conversion → DONE_o after 56 enabled-or-not cycles, correct result. XARST_i low at cycle 10 → no DONE_o, QQ_o=0.
- With BIN2BCD_SEQ_LZB_EN, DAT_i=405 → QQ_o=36'hFFFFFF405. DAT_i=0 → 36'hFFFFFFFF0. Without the macro, 36'h000000405.
